nes_pad_reader: RTL
===================

Name: nes_pad_reader

Overview:
- NES controller serial reader inside the TinyQV byte peripheral. Drives the pad's latch and clock lines and samples its serial data line.
- Presents the 8 button states as an active-high byte to the peripheral register/interrupt logic downstream.
- Polls on a software start strobe or on an internal auto-poll timer.
- Pin mapping at harness top: latch on uo_out[6], clock on uo_out[7], data on ui_in[1].

Parameters:
- HALF_PERIOD, 384, clk cycles per NES clock half-period (6 us at 64 MHz); must be >= 4.
- POLL_CYCLES, 1066667, clk cycles between auto-poll ticks (~60 Hz at 64 MHz); must be > 16*HALF_PERIOD+2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle poll request; honoured only in IDLE.
- auto_en_i  in  1  enables periodic auto-poll.
- nes_data_i  in  1  serial data from pad; active-low (0 = pressed); idles high via pull-up.
- nes_latch_o  out  1  pad latch, active-high.
- nes_clk_o  out  1  pad shift clock.
- buttons_o  out  8  last completed reading, active-high: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
- valid_o  out  1  one-cycle pulse when buttons_o updates.
- changed_o  out  1  one-cycle pulse, coincident with valid_o, when the new buttons_o differs from the previous value.
- busy_o  out  1  high whenever FSM is not IDLE.

Behaviour:
- Clock and reset:
  - Single clock; reset is asynchronous and active-low.
  - While rst_n=0: all outputs 0, buttons_o=8'h00, FSM=IDLE, counters=0, shift register=8'hFF.
  - All outputs are registered.
- FSM states: IDLE, LATCH, CLK_HI, CLK_LO, DONE.
  - One phase counter (0..2*HALF_PERIOD-1) and one bit index (1..7).
- IDLE:
  - nes_latch_o=0, nes_clk_o=0.
  - Goes to LATCH when start_i=1 or an auto-poll tick occurs. If both happen in the same cycle, only one transaction starts.
- LATCH:
  - nes_latch_o=1 for exactly 2*HALF_PERIOD cycles.
  - On the last LATCH cycle: sample data into raw[0], set bit index=1, go to CLK_HI.
- CLK_HI:
  - nes_clk_o=1 for HALF_PERIOD cycles, then go to CLK_LO.
- CLK_LO:
  - nes_clk_o=0 for HALF_PERIOD cycles.
  - On the last CLK_LO cycle: sample data into raw[index].
  - If index=7, go to DONE; else increment index and go to CLK_HI.
  - Exactly 7 nes_clk_o pulses per transaction.
- DONE (1 cycle):
  - buttons_o <= ~raw; valid_o=1; changed_o=1 iff ~raw != previous buttons_o.
  - Next state IDLE.
- Latency:
  - start_i high in cycle t (IDLE): nes_latch_o rises at t+1.
  - Transaction = 16*HALF_PERIOD cycles; valid_o asserted in cycle t+1+16*HALF_PERIOD.
  - busy_o high from t+1 through the DONE cycle inclusive.
- Auto-poll timer:
  - Counts 0..POLL_CYCLES-1 and wraps; held at 0 while auto_en_i=0.
  - Tick = (count==POLL_CYCLES-1 && auto_en_i).
  - A tick or start_i arriving while busy is dropped (no queuing).
- Reset mid-transaction: outputs drop to 0 immediately and asynchronously; no valid_o; buttons_o=0.
- Unplugged pad (data constantly 1): reads as buttons_o=8'h00; no error indication.

Optional Feature:
- Macro: NES_DATA_SYNC_EN.
- Defined: nes_data_i passes through a 2-flop synchronizer (both flops reset to 1) before sampling. Sample points and latency are unchanged; the sampled value is nes_data_i from 2 cycles earlier.
- Undefined: nes_data_i is sampled directly, and the caller guarantees it is synchronous. Used for gate-level test speed.

Test Plan:
- Reset values: assert rst_n=0 with random inputs -> nes_latch_o=0, nes_clk_o=0, buttons_o=8'h00, valid_o=0, changed_o=0, busy_o=0.
- Single poll (HALF_PERIOD=4), pad model pressing A+Right (raw bits 0 and 7 = 0) -> latch high 8 cycles starting at t+1, exactly 7 clk pulses of 4 high/4 low, valid_o at t+65, buttons_o=8'h81, changed_o=1.
- Repeat the same press -> buttons_o=8'h81, valid_o=1, changed_o=0. Release all (data=1) -> buttons_o=8'h00, changed_o=1.
- start_i pulsed at t+10 and t+40 during a transaction -> exactly one latch pulse, one valid_o; busy_o high from t+1 to t+65.
- Auto-poll with POLL_CYCLES=200, auto_en_i=1 for 1000 cycles -> nes_latch_o rises every 200 cycles, 5 valid_o pulses. auto_en_i=0 -> no further latches.
- rst_n pulsed low at t+30 mid-transaction -> nes_clk_o/nes_latch_o=0 the same cycle, no valid_o; after release, a new start_i completes normally with the correct byte.

Source files
------------

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: serial reader for an NES controller.
//
// Drives the pad latch and shift clock, samples the active-low serial data line and presents
// the eight buttons as an active-high byte. A poll starts on start_i or on an internal auto-poll
// tick. Every output is registered.
//
// Optional build macro NES_DATA_SYNC_EN: when defined, nes_data_i passes through a 2-flop
// synchronizer (reset to 1) before sampling. When undefined, nes_data_i is sampled directly and
// must already be synchronous to clk.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start_i      one-cycle poll request, honoured only when idle
//   auto_en_i    enables the periodic auto-poll timer
//   nes_data_i   pad serial data, active-low (0 = pressed)
//   nes_latch_o  pad latch, active-high
//   nes_clk_o    pad shift clock
//   buttons_o    last reading: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//   valid_o      one-cycle pulse when buttons_o updates
//   changed_o    one-cycle pulse with valid_o when the new reading differs from the old one
//   busy_o       high while a transaction is in progress

module nes_pad_reader #(
   parameter int unsigned HALF_PERIOD = 384,
   parameter int unsigned POLL_CYCLES = 1066667
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic       auto_en_i,
   input  logic       nes_data_i,
   output logic       nes_latch_o,
   output logic       nes_clk_o,
   output logic [7:0] buttons_o,
   output logic       valid_o,
   output logic       changed_o,
   output logic       busy_o
);

   localparam int unsigned PhaseW = $clog2(2 * HALF_PERIOD);
   localparam int unsigned PollW  = $clog2(POLL_CYCLES);

   localparam logic [PhaseW-1:0] LatchLast = PhaseW'(2 * HALF_PERIOD - 1);
   localparam logic [PhaseW-1:0] HalfLast  = PhaseW'(HALF_PERIOD - 1);
   localparam logic [PollW-1:0]  PollLast  = PollW'(POLL_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StLatch, StClkHi, StClkLo, StDone} state_e;

   state_e              state_q, state_d;
   logic [PhaseW-1:0]   phase_q, phase_d;
   logic [2:0]          idx_q, idx_d;
   logic [7:0]          raw_q, raw_d;
   logic [PollW-1:0]    poll_q, poll_d;
   logic [7:0]          buttons_q, buttons_d;
   logic                latch_q, latch_d;
   logic                nclk_q, nclk_d;
   logic                valid_q, valid_d;
   logic                changed_q, changed_d;
   logic                busy_q, busy_d;
   logic                poll_tick;
   logic                data_s;

`ifdef NES_DATA_SYNC_EN
   logic [1:0] sync_q;

   // Reset to 1 so an idle (pulled-up) line never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], nes_data_i};
      end
   end

   assign data_s = sync_q[1];
`else
   assign data_s = nes_data_i;
`endif

   always_comb begin
      poll_tick = auto_en_i && (poll_q == PollLast);
      if (!auto_en_i || poll_tick) begin
         poll_d = '0;
      end else begin
         poll_d = poll_q + PollW'(1);
      end

      state_d   = state_q;
      phase_d   = phase_q;
      idx_d     = idx_q;
      raw_d     = raw_q;
      buttons_d = buttons_q;
      changed_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            // start_i and a tick in the same cycle still launch just one transaction.
            if (start_i || poll_tick) begin
               state_d = StLatch;
               phase_d = '0;
            end
         end
         StLatch: begin
            if (phase_q == LatchLast) begin
               raw_d[0] = data_s;
               idx_d    = 3'd1;
               phase_d  = '0;
               state_d  = StClkHi;
            end else begin
               phase_d = phase_q + PhaseW'(1);
            end
         end
         StClkHi: begin
            if (phase_q == HalfLast) begin
               phase_d = '0;
               state_d = StClkLo;
            end else begin
               phase_d = phase_q + PhaseW'(1);
            end
         end
         StClkLo: begin
            if (phase_q == HalfLast) begin
               raw_d[idx_q] = data_s;
               phase_d      = '0;
               if (idx_q == 3'd7) begin
                  // Result is loaded on entry to DONE so it lines up with valid_o.
                  state_d   = StDone;
                  buttons_d = ~raw_d;
                  changed_d = (~raw_d != buttons_q);
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = StClkHi;
               end
            end else begin
               phase_d = phase_q + PhaseW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are registered from the next state so they align with the state itself.
      latch_d = (state_d == StLatch);
      nclk_d  = (state_d == StClkHi);
      valid_d = (state_d == StDone);
      busy_d  = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         phase_q   <= '0;
         idx_q     <= '0;
         raw_q     <= 8'hFF;
         poll_q    <= '0;
         buttons_q <= 8'h00;
         latch_q   <= 1'b0;
         nclk_q    <= 1'b0;
         valid_q   <= 1'b0;
         changed_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         idx_q     <= idx_d;
         raw_q     <= raw_d;
         poll_q    <= poll_d;
         buttons_q <= buttons_d;
         latch_q   <= latch_d;
         nclk_q    <= nclk_d;
         valid_q   <= valid_d;
         changed_q <= changed_d;
         busy_q    <= busy_d;
      end
   end

   assign nes_latch_o = latch_q;
   assign nes_clk_o   = nclk_q;
   assign buttons_o   = buttons_q;
   assign valid_o     = valid_q;
   assign changed_o   = changed_q;
   assign busy_o      = busy_q;

endmodule
